// File: rtl/periph_reg_responder.sv
// periph_reg_responder: peripheral register window (ID/CTRL/STATUS/SCRATCH) with a hardware-fed result FIFO
module periph_reg_responder #(
  parameter logic [31:0] ID_VALUE   = 32'h474E_5353,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  input  logic        push_valid,
  input  logic [31:0] push_data,
  output logic        ctrl_enable,
  output logic        irq
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state_q, state_d;
  logic [31:0] ctrl_q, ctrl_d, scratch_q, scratch_d, rdata_q, rdata_d, status, rmux, head;
  logic [CNT_W-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [31:0] mem [FIFO_DEPTH];
  logic ovf_q, ovf_d, accept, wr, rd, empty, full, flush, pop, push, ovf_set, ovf_clr;
  logic [5:0] sel;
  logic unused_addr;
  assign unused_addr = ^{mem_addr[31:8], mem_addr[1:0]};
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb state_d = (state_q == IDLE && mem_valid) ? RESP : IDLE;
  always_comb mem_ready = (state_q == RESP);
  assign accept  = (state_q == IDLE) && mem_valid;
  assign wr      = accept && |mem_wstrb;
  assign rd      = accept && !(|mem_wstrb);
  assign sel     = mem_addr[7:2];
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign flush   = wr && sel == 6'h1 && mem_wstrb[0] && mem_wdata[1];
  assign pop     = rd && sel == 6'h3 && !empty;
  // A same-edge pop frees a slot, so a push into a full FIFO still lands
  assign push    = push_valid && !flush && (!full || pop);
  assign ovf_set = push_valid && !flush && full && !pop;
  assign ovf_clr = wr && sel == 6'h2 && mem_wstrb[0] && mem_wdata[2];
  assign ovf_d   = ovf_set || (ovf_q && !ovf_clr);
  assign count_d = flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
  assign head    = empty ? '0 : mem[rd_ptr_q];
  always_comb begin
    status = '0;
    status[0] = empty;
    status[1] = full;
    status[2] = ovf_q;
    status[8 +: CNT_W] = count_q;
  end
  always_comb
    rmux = sel == 6'h0 ? ID_VALUE :
           sel == 6'h1 ? ctrl_q :
           sel == 6'h2 ? status :
           sel == 6'h3 ? head :
           sel == 6'h4 ? scratch_q : '0;
  assign rdata_d = rd ? rmux : '0;
  always_comb begin
    ctrl_d = ctrl_q;
    scratch_d = scratch_q;
    for (int b = 0; b < 4; b++) begin
      ctrl_d[8*b +: 8]    = (wr && sel == 6'h1 && mem_wstrb[b]) ? mem_wdata[8*b +: 8] : ctrl_q[8*b +: 8];
      scratch_d[8*b +: 8] = (wr && sel == 6'h4 && mem_wstrb[b]) ? mem_wdata[8*b +: 8] : scratch_q[8*b +: 8];
    end
    ctrl_d[1] = 1'b0;
  end
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      ctrl_q    <= '0;
      scratch_q <= '0;
      rdata_q   <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
      if (accept) rdata_q <= rdata_d;
      wr_ptr_q  <= flush ? '0 : wr_ptr_q + AW'(push);
      rd_ptr_q  <= flush ? '0 : rd_ptr_q + AW'(pop);
    end
  always_ff @(posedge sys_clk)
    if (push) mem[wr_ptr_q] <= push_data;
  assign mem_rdata   = rdata_q;
  assign ctrl_enable = ctrl_q[0];
  assign irq         = ctrl_q[2] && !empty;
endmodule

// File: tb/tb_periph_reg_responder.sv
// tb_periph_reg_responder: directed self-checking bench for the peripheral register responder
module tb_periph_reg_responder;
  logic sys_clk = 1'b0, rst_n = 1'b0;
  logic mem_valid = 1'b0, mem_ready, push_valid = 1'b0, ctrl_enable, irq;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata, push_data = '0;
  logic [3:0] mem_wstrb = '0;
  int checks = 0, failures = 0;
  logic [31:0] rd;
  int lat;
  logic rdy2;
  periph_reg_responder dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .push_valid(push_valid), .push_data(push_data), .ctrl_enable(ctrl_enable), .irq(irq)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input logic p, input logic [31:0] pd,
                        output logic [31:0] r, output int l, output logic ready_after);
    @(negedge sys_clk);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    push_valid = p; push_data = pd;
    l = 0;
    do begin
      @(posedge sys_clk); #1;
      push_valid = 1'b0;
      l++;
    end while (!mem_ready && l < 5);
    r = mem_rdata;
    mem_valid = 1'b0; mem_wstrb = '0;
    @(posedge sys_clk); #1;
    ready_after = mem_ready;
  endtask
  task automatic push_word(input logic [31:0] d);
    @(negedge sys_clk);
    push_valid = 1'b1; push_data = d;
    @(posedge sys_clk); #1;
    push_valid = 1'b0;
  endtask
  task automatic test_reset;
    #1;
    checks++; if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_bus ready=%b rdata=%h want 0/0", mem_ready, mem_rdata); end
    checks++; if (ctrl_enable !== 1'b0 || irq !== 1'b0) begin failures++; $display("FAIL reset_out en=%b irq=%b want 0/0", ctrl_enable, irq); end
    @(negedge sys_clk); rst_n = 1'b1;
    access(32'h00, 0, 4'h0, 0, 0, rd, lat, rdy2);
    checks++; if (lat !== 1 || rdy2 !== 1'b0) begin failures++; $display("FAIL id_latency lat=%0d ready_after=%b want 1/0", lat, rdy2); end
    checks++; if (rd !== 32'h474E_5353) begin failures++; $display("FAIL id_read got=%h want 474e5353", rd); end
    access(32'h08, 0, 4'h0, 0, 0, rd, lat, rdy2);
    checks++; if (rd !== 32'h0000_0001) begin failures++; $display("FAIL status_reset got=%h want 00000001", rd); end
  endtask
  task automatic test_regs;
    access(32'h10, 32'hA5A5_A5A5, 4'b0101, 0, 0, rd, lat, rdy2);
    access(32'h10, 0, 4'h0, 0, 0, rd, lat, rdy2);
    checks++; if (rd !== 32'h00A5_00A5) begin failures++; $display("FAIL scratch_strb got=%h want 00a500a5", rd); end
    access(32'h20, 0, 4'h0, 0, 0, rd, lat, rdy2);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL unmapped got=%h want 0", rd); end
    access(32'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, rd, lat, rdy2);
    access(32'h00, 0, 4'h0, 0, 0, rd, lat, rdy2);
    checks++; if (rd !== 32'h474E_5353) begin failures++; $display("FAIL id_ro got=%h want 474e5353", rd); end
    access(32'hABCD_0110, 0, 4'h0, 0, 0, rd, lat, rdy2);
    checks++; if (rd !== 32'h00A5_00A5) begin failures++; $display("FAIL high_addr got=%h want 00a500a5", rd); end
  endtask
  task automatic test_fifo_basic;
    push_word(1); push_word(2); push_word(3);
    access(32'h08, 0, 4'h0, 0, 0, rd, lat, rdy2);
    checks++; if (rd !== 32'h0000_0300) begin failures++; $display("FAIL count3 got=%h want 00000300", rd); end
    for (int i = 1; i <= 4; i++) begin
      access(32'h0C, 0, 4'h0, 0, 0, rd, lat, rdy2);
      checks++; if (rd !== (i == 4 ? 32'h0 : 32'(i))) begin failures++; $display("FAIL pop%0d got=%h want %h", i, rd, (i == 4 ? 32'h0 : 32'(i))); end
    end
    access(32'h08, 0, 4'h0, 0, 0, rd, lat, rdy2);
    checks++; if (rd !== 32'h0000_0001) begin failures++; $display("FAIL empty_after got=%h want 00000001", rd); end
  endtask
  task automatic test_overflow;
    for (int i = 1; i <= 17; i++) push_word(32'(i));
    access(32'h08, 0, 4'h0, 0, 0, rd, lat, rdy2);
    checks++; if (rd !== 32'h0000_1006) begin failures++; $display("FAIL full_ovf got=%h want 00001006", rd); end
    for (int i = 1; i <= 16; i++) begin
      access(32'h0C, 0, 4'h0, 0, 0, rd, lat, rdy2);
      checks++; if (rd !== 32'(i)) begin failures++; $display("FAIL ovf_pop%0d got=%h want %h", i, rd, 32'(i)); end
    end
    access(32'h08, 0, 4'h0, 0, 0, rd, lat, rdy2);
    checks++; if (rd !== 32'h0000_0005) begin failures++; $display("FAIL ovf_sticky got=%h want 00000005", rd); end
    access(32'h08, 32'h4, 4'b0001, 0, 0, rd, lat, rdy2);
    access(32'h08, 0, 4'h0, 0, 0, rd, lat, rdy2);
    checks++; if (rd !== 32'h0000_0001) begin failures++; $display("FAIL w1c got=%h want 00000001", rd); end
  endtask
  task automatic test_simul;
    for (int i = 0; i < 16; i++) push_word(32'(100 + i));
    access(32'h0C, 0, 4'h0, 1, 32'd200, rd, lat, rdy2);
    checks++; if (rd !== 32'd100) begin failures++; $display("FAIL full_pushpop got=%h want %h", rd, 32'd100); end
    access(32'h08, 0, 4'h0, 0, 0, rd, lat, rdy2);
    checks++; if (rd !== 32'h0000_1002) begin failures++; $display("FAIL full_pushpop_stat got=%h want 00001002", rd); end
    for (int i = 1; i <= 16; i++) begin
      access(32'h0C, 0, 4'h0, 0, 0, rd, lat, rdy2);
      checks++; if (rd !== (i == 16 ? 32'd200 : 32'(100 + i))) begin failures++; $display("FAIL drain%0d got=%h want %h", i, rd, (i == 16 ? 32'd200 : 32'(100 + i))); end
    end
    access(32'h0C, 0, 4'h0, 1, 32'd300, rd, lat, rdy2);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL empty_pushpop got=%h want 0", rd); end
    access(32'h08, 0, 4'h0, 0, 0, rd, lat, rdy2);
    checks++; if (rd !== 32'h0000_0100) begin failures++; $display("FAIL empty_pushpop_stat got=%h want 00000100", rd); end
    access(32'h0C, 0, 4'h0, 0, 0, rd, lat, rdy2);
    checks++; if (rd !== 32'd300) begin failures++; $display("FAIL empty_pushpop_data got=%h want %h", rd, 32'd300); end
  endtask
  task automatic test_ctrl;
    push_word(32'h11); push_word(32'h22);
    access(32'h04, 32'h5, 4'hF, 0, 0, rd, lat, rdy2);
    checks++; if (ctrl_enable !== 1'b1 || irq !== 1'b1) begin failures++; $display("FAIL ctrl_irq en=%b irq=%b want 1/1", ctrl_enable, irq); end
    access(32'h04, 32'h7, 4'b0001, 1, 32'h33, rd, lat, rdy2);
    access(32'h08, 0, 4'h0, 0, 0, rd, lat, rdy2);
    checks++; if (rd !== 32'h0000_0001) begin failures++; $display("FAIL flush_stat got=%h want 00000001", rd); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL flush_irq got=%b want 0", irq); end
    access(32'h04, 0, 4'h0, 0, 0, rd, lat, rdy2);
    checks++; if (rd !== 32'h0000_0005) begin failures++; $display("FAIL ctrl_read got=%h want 00000005", rd); end
  endtask
  task automatic test_reset_mid;
    @(negedge sys_clk);
    mem_valid = 1'b1; mem_addr = 32'h0; mem_wstrb = '0;
    @(posedge sys_clk); #1;
    checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL mid_resp got=%b want 1", mem_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_ready !== 1'b0 || ctrl_enable !== 1'b0) begin failures++; $display("FAIL async_reset ready=%b en=%b want 0/0", mem_ready, ctrl_enable); end
    @(negedge sys_clk); mem_valid = 1'b0; rst_n = 1'b1;
    access(32'h00, 0, 4'h0, 0, 0, rd, lat, rdy2);
    checks++; if (rd !== 32'h474E_5353 || lat !== 1) begin failures++; $display("FAIL restart got=%h lat=%0d want 474e5353/1", rd, lat); end
  endtask
  initial begin
    test_reset;
    test_regs;
    test_fifo_basic;
    test_overflow;
    test_simul;
    test_ctrl;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
